// File: rtl/uart_num_parser_if.sv
// Byte-in / number-out bundle between the UART receiver side and the number tokenizer.
interface uart_num_parser_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  uart_rx_done;
    logic [7:0]            uart_rx_data;
    logic                  clr;
    logic                  num_valid;
    logic [DATA_WIDTH-1:0] num_data;
    logic                  line_end;
    logic [7:0]            line_len;
    logic                  err;

    modport master (
        output uart_rx_done, uart_rx_data, clr,
        input  num_valid, num_data, line_end, line_len, err
    );

    modport slave (
        input  uart_rx_done, uart_rx_data, clr,
        output num_valid, num_data, line_end, line_len, err
    );
endinterface

// File: rtl/uart_num_parser.sv
// Tokenizes ASCII signed decimal integers from a UART byte stream into range-checked
// numbers, with an end-of-line strobe carrying the count of numbers on that line.
module uart_num_parser #(
    parameter int DATA_WIDTH = 8,
    parameter int MIN_VAL    = -128,
    parameter int MAX_VAL    = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_num_parser_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_SIGN, S_DIGIT, S_SKIP} state_e;
    typedef enum logic [2:0] {C_DIGIT, C_MINUS, C_SEP, C_TERM, C_OTHER} cls_e;

    state_e      state;
    logic [15:0] acc;
    logic        neg;
    logic        ovf;
    logic [7:0]  cnt;
    logic        line_active;

    cls_e               cls;
    logic [15:0]        dig;
    logic [19:0]        acc_mac;
    logic               acc_big;
    logic signed [16:0] value;
    logic signed [31:0] val32;
    logic               in_range;
    logic               tok_close;
    logic               tok_err_close;
    logic               closes_ok;
    logic [7:0]         cnt_after;
    logic               active_after;

    always_comb begin
        cls = C_OTHER;
        if (bus.uart_rx_data >= 8'h30 && bus.uart_rx_data <= 8'h39) cls = C_DIGIT;
        else if (bus.uart_rx_data == 8'h2D)                          cls = C_MINUS;
        else if (bus.uart_rx_data == 8'h20 || bus.uart_rx_data == 8'h2C ||
                 bus.uart_rx_data == 8'h09)                          cls = C_SEP;
        else if (bus.uart_rx_data == 8'h0D || bus.uart_rx_data == 8'h0A) cls = C_TERM;

        dig     = {12'd0, bus.uart_rx_data[3:0]};
        acc_mac = {4'd0, acc} * 20'd10 + {4'd0, dig};
        acc_big = acc_mac > 20'd32767;

        value    = neg ? (17'd0 - {1'b0, acc}) : {1'b0, acc};
        val32    = {{15{value[16]}}, value};
        in_range = !ovf && (val32 >= MIN_VAL) && (val32 <= MAX_VAL);

        tok_close     = (state == S_DIGIT) && (cls == C_SEP || cls == C_TERM);
        tok_err_close = (state == S_SIGN || state == S_SKIP) && (cls == C_SEP || cls == C_TERM);
        closes_ok     = tok_close && in_range;

        // The token closed by a terminator counts toward the line it terminates.
        cnt_after    = (closes_ok && cnt != 8'hFF) ? cnt + 8'd1 : cnt;
        active_after = line_active | tok_close | tok_err_close;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            acc           <= '0;
            neg           <= 1'b0;
            ovf           <= 1'b0;
            cnt           <= '0;
            line_active   <= 1'b0;
            bus.num_valid <= 1'b0;
            bus.num_data  <= '0;
            bus.line_end  <= 1'b0;
            bus.line_len  <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.num_valid <= 1'b0;
            bus.line_end  <= 1'b0;
            bus.err       <= 1'b0;
            if (bus.clr) begin
                state       <= S_IDLE;
                acc         <= '0;
                neg         <= 1'b0;
                ovf         <= 1'b0;
                cnt         <= '0;
                line_active <= 1'b0;
            end else if (bus.uart_rx_done) begin
                case (state)
                    S_IDLE: begin
                        case (cls)
                            C_DIGIT: begin acc <= dig; neg <= 1'b0; ovf <= 1'b0; state <= S_DIGIT; end
                            C_MINUS: begin acc <= '0;  neg <= 1'b1; ovf <= 1'b0; state <= S_SIGN; end
                            C_OTHER: state <= S_SKIP;
                            default: state <= S_IDLE;
                        endcase
                    end
                    S_SIGN: begin
                        case (cls)
                            C_DIGIT:      begin acc <= dig; state <= S_DIGIT; end
                            C_SEP, C_TERM: begin bus.err <= 1'b1; state <= S_IDLE; end
                            default:      state <= S_SKIP;
                        endcase
                    end
                    S_DIGIT: begin
                        case (cls)
                            C_DIGIT: begin
                                // Once overflowed, acc freezes; ovf alone decides the outcome.
                                if (!ovf) begin
                                    if (acc_big) ovf <= 1'b1;
                                    else         acc <= acc_mac[15:0];
                                end
                            end
                            C_SEP, C_TERM: begin
                                if (in_range) begin
                                    bus.num_valid <= 1'b1;
                                    bus.num_data  <= val32[DATA_WIDTH-1:0];
                                end else begin
                                    bus.err <= 1'b1;
                                end
                                ovf   <= 1'b0;
                                state <= S_IDLE;
                            end
                            default: state <= S_SKIP;
                        endcase
                    end
                    default: begin
                        if (cls == C_SEP || cls == C_TERM) begin
                            bus.err <= 1'b1;
                            ovf     <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                endcase

                if (cls == C_TERM && active_after) begin
                    bus.line_end <= 1'b1;
                    bus.line_len <= cnt_after;
                    cnt          <= '0;
                    line_active  <= 1'b0;
                end else begin
                    cnt         <= cnt_after;
                    line_active <= active_after;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_num_parser.sv
// Randomized and directed check of uart_num_parser against a token-level text model.
module tb_uart_num_parser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_num_parser_if #(.DATA_WIDTH(8)) bus ();

    uart_num_parser #(.DATA_WIDTH(8), .MIN_VAL(-128), .MAX_VAL(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: collect raw token text, judge it whole when a blank or terminator arrives.
    logic [7:0] tok[$];
    int         m_cnt    = 0;
    bit         m_active = 0;
    logic [7:0] m_data   = 8'd0;
    logic [7:0] m_len    = 8'd0;

    function automatic void model_reset();
        tok.delete();
        m_cnt    = 0;
        m_active = 0;
        m_data   = 8'd0;
        m_len    = 8'd0;
    endfunction

    function automatic void eval_token(output bit ok, output int val);
        int  i0;
        int  mag;
        bit  bad;
        bit  big;
        i0  = (tok[0] == 8'h2D) ? 1 : 0;
        mag = 0;
        bad = (tok.size() <= i0);
        big = 0;
        for (int i = i0; i < tok.size(); i++) begin
            if (tok[i] < 8'h30 || tok[i] > 8'h39) bad = 1;
            else if (!big) begin
                mag = mag * 10 + int'(tok[i]) - 48;
                if (mag > 32767) big = 1;
            end
        end
        val = (i0 == 1) ? -mag : mag;
        ok  = !bad && !big && val >= -128 && val <= 127;
    endfunction

    function automatic logic [18:0] model_step(input logic d, input logic [7:0] b, input logic c);
        logic nv;
        logic er;
        logic le;
        bit   sep;
        bit   term;
        bit   ok;
        int   val;
        nv   = 0;
        er   = 0;
        le   = 0;
        sep  = (b == 8'h20 || b == 8'h2C || b == 8'h09);
        term = (b == 8'h0D || b == 8'h0A);
        if (c) begin
            tok.delete();
            m_cnt    = 0;
            m_active = 0;
        end else if (d) begin
            if (sep || term) begin
                if (tok.size() > 0) begin
                    eval_token(ok, val);
                    m_active = 1;
                    if (ok) begin
                        nv     = 1;
                        m_data = val[7:0];
                        if (m_cnt < 255) m_cnt++;
                    end else begin
                        er = 1;
                    end
                    tok.delete();
                end
                if (term && m_active) begin
                    le       = 1;
                    m_len    = m_cnt[7:0];
                    m_cnt    = 0;
                    m_active = 0;
                end
            end else begin
                tok.push_back(b);
            end
        end
        return {nv, er, le, m_data, m_len};
    endfunction

    // Called at a negedge; drives one cycle and samples its registered result at the next negedge.
    task automatic apply(input logic d, input logic [7:0] b, input logic c,
                         output logic [18:0] obs, output logic [18:0] exp);
        bus.uart_rx_done = d;
        bus.uart_rx_data = b;
        bus.clr          = c;
        exp = model_step(d, b, c);
        @(negedge clk);
        obs = {bus.num_valid, bus.err, bus.line_end, bus.num_data, bus.line_len};
        bus.uart_rx_done = 1'b0;
        bus.clr          = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        rst_n = 1'b0;
        model_reset();
        #3;
        obs = {bus.num_valid, bus.err, bus.line_end, bus.num_data, bus.line_len};
        n_cmp++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL reset: outputs %h, expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        string s;
        logic [18:0] obs, exp;
        s = "12 -7\r\n";
        for (int i = 0; i < s.len(); i++) begin
            apply(1'b1, s[i], 1'b0, obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL basic byte %0d: got %h expected %h", i, obs, exp);
            end
        end
        n_cmp++;
        if (bus.num_data !== 8'hF9 || bus.line_len !== 8'd2) begin
            n_fail++;
            $display("FAIL basic hold: data %h len %0d, expected f9 len 2", bus.num_data, bus.line_len);
        end
    endtask

    task automatic test_range();
        string s;
        logic [18:0] obs, exp;
        s = "128,-128,127\n";
        for (int i = 0; i < s.len(); i++) begin
            apply(1'b1, s[i], 1'b0, obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL range byte %0d: got %h expected %h", i, obs, exp);
            end
        end
        n_cmp++;
        if (bus.num_data !== 8'h7F || bus.line_len !== 8'd2) begin
            n_fail++;
            $display("FAIL range hold: data %h len %0d, expected 7f len 2", bus.num_data, bus.line_len);
        end
    endtask

    task automatic test_overflow();
        string s;
        logic [18:0] obs, exp;
        s = "99999999 5\n";
        for (int i = 0; i < s.len(); i++) begin
            apply(1'b1, s[i], 1'b0, obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL overflow byte %0d: got %h expected %h", i, obs, exp);
            end
        end
        n_cmp++;
        if (bus.num_data !== 8'h05 || bus.line_len !== 8'd1) begin
            n_fail++;
            $display("FAIL overflow hold: data %h len %0d, expected 05 len 1", bus.num_data, bus.line_len);
        end
    endtask

    task automatic test_malformed();
        string s;
        logic [18:0] obs, exp;
        s = "-\n1a2 3\n-0\t\n";
        for (int i = 0; i < s.len(); i++) begin
            apply(1'b1, s[i], 1'b0, obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL malformed byte %0d: got %h expected %h", i, obs, exp);
            end
        end
        n_cmp++;
        if (bus.num_data !== 8'h00 || bus.line_len !== 8'd1) begin
            n_fail++;
            $display("FAIL malformed hold: data %h len %0d, expected 00 len 1", bus.num_data, bus.line_len);
        end
    endtask

    task automatic test_clr();
        string s;
        logic [18:0] obs, exp;
        s = "45";
        for (int i = 0; i < s.len(); i++) apply(1'b1, s[i], 1'b0, obs, exp);
        apply(1'b0, 8'h00, 1'b1, obs, exp);
        apply(1'b1, 8'h20, 1'b0, obs, exp);
        n_cmp++;
        if (obs !== exp || obs[18:16] !== 3'b000) begin
            n_fail++;
            $display("FAIL clr space: got %h expected %h", obs, exp);
        end
        apply(1'b1, 8'h0A, 1'b0, obs, exp);
        n_cmp++;
        if (obs !== exp || obs[18:16] !== 3'b000) begin
            n_fail++;
            $display("FAIL clr newline: got %h expected %h", obs, exp);
        end
        for (int i = 0; i < s.len(); i++) apply(1'b1, s[i], 1'b0, obs, exp);
        apply(1'b1, 8'h20, 1'b1, obs, exp);
        n_cmp++;
        if (obs !== exp || obs[18:16] !== 3'b000) begin
            n_fail++;
            $display("FAIL clr with sep: got %h expected %h", obs, exp);
        end
        apply(1'b1, 8'h0A, 1'b0, obs, exp);
        n_cmp++;
        if (obs !== exp || bus.num_data !== 8'h00 || bus.line_len !== 8'd1) begin
            n_fail++;
            $display("FAIL clr hold: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        string s;
        logic [18:0] obs, exp;
        s = "7 8";
        for (int i = 0; i < s.len(); i++) begin
            apply(1'b1, s[i], 1'b0, obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid byte %0d: got %h expected %h", i, obs, exp);
            end
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        obs = {bus.num_valid, bus.err, bus.line_end, bus.num_data, bus.line_len};
        n_cmp++;
        if (obs !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %h expected 0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, 8'h0A, 1'b0, obs, exp);
        n_cmp++;
        if (obs !== exp || obs !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid newline: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_saturation();
        logic [18:0] obs, exp;
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 8'h31, 1'b0, obs, exp);
            apply(1'b1, 8'h20, 1'b0, obs, exp);
        end
        apply(1'b1, 8'h0A, 1'b0, obs, exp);
        n_cmp++;
        if (obs !== exp || bus.line_len !== 8'd255 || bus.line_end !== 1'b1) begin
            n_fail++;
            $display("FAIL saturation: got %h expected %h (len 255)", obs, exp);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [18:0] obs, exp;
        logic [7:0]  b;
        int          r;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 45) b = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 55) b = 8'h2D;
            else if (r < 72) b = 8'h20;
            else if (r < 77) b = 8'h2C;
            else if (r < 80) b = 8'h09;
            else if (r < 87) b = 8'h0A;
            else if (r < 91) b = 8'h0D;
            else             b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) apply(1'b0, 8'h00, 1'b0, obs, exp);
            apply(1'b1, b, ($urandom_range(0, 99) == 0), obs, exp);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random step %0d byte %h: got %h expected %h", n, b, obs, exp);
            end
        end
    endtask

    initial begin
        bus.uart_rx_done = 1'b0;
        bus.uart_rx_data = 8'h00;
        bus.clr          = 1'b0;
        test_reset();
        test_basic();
        test_range();
        test_overflow();
        test_malformed();
        test_clr();
        test_reset_mid();
        test_saturation();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_num_parser.md
# uart_num_parser

Byte-stream tokenizer sitting directly downstream of the UART receiver. It consumes one received byte per `uart_rx_done` strobe and parses ASCII signed decimal integers separated by blanks/commas and grouped into lines. It emits one range-checked number per token plus an end-of-line strobe with the count of numbers on that line. The matrix-input FSM uses these to fill elements and infer column count.

## Interface

Parameters:
- `DATA_WIDTH`, 8: width of signed `num_data`.
- `MIN_VAL`, -128: smallest accepted value (signed, inclusive).
- `MAX_VAL`, 127: largest accepted value (signed, inclusive).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `uart_rx_done`  input  1  one-cycle strobe: `uart_rx_data` holds a new byte.
- `uart_rx_data`  input  8  received byte.
- `clr`  input  1  synchronous flush: return to IDLE, discard partial token, zero the line count.
- `num_valid`  output  1  one-cycle strobe: `num_data` is a valid number.
- `num_data`  output  DATA_WIDTH  parsed value, two's complement; holds last value between strobes.
- `line_end`  output  1  one-cycle strobe: a line terminator closed a non-empty line.
- `line_len`  output  8  numbers accepted on the closed line; valid with `line_end`, holds otherwise.
- `err`  output  1  one-cycle strobe: a malformed or out-of-range token was dropped.

## Operation

- Byte classes: DIGIT `0x30-0x39`; MINUS `0x2D`; SEP space `0x20`, comma `0x2C`, tab `0x09`; TERM CR `0x0D`, LF `0x0A`; OTHER = everything else.
- State is updated only on cycles with `uart_rx_done=1`. States:
  - IDLE: DIGIT -> acc=d, neg=0, DIGIT. MINUS -> acc=0, neg=1, SIGN. SEP -> stay. TERM -> line-end check. OTHER -> SKIP.
  - SIGN: DIGIT -> acc=d, DIGIT. SEP/TERM -> `err`, IDLE. MINUS/OTHER -> SKIP.
  - DIGIT: DIGIT -> acc=acc*10+d. If the result exceeds 32767, set sticky `ovf` and stop updating acc. SEP/TERM -> close token, IDLE. MINUS/OTHER -> SKIP.
  - SKIP: SEP/TERM -> `err`, IDLE. Else stay.
- Accumulator is 16-bit unsigned. Value = neg ? -acc : acc, computed in 17-bit signed.
- Closing a token: if `ovf`, or value < MIN_VAL, or value > MAX_VAL, pulse `err`. Otherwise pulse `num_valid`, load `num_data` with the low DATA_WIDTH bits, and increment the line counter (saturates at 255). Clear `ovf`.
- "-0" is accepted as 0.
- Line tracking: `line_active` is set by any token close (valid or err).
- On a TERM byte, the token closed by that byte (if any) is counted first. Then, if `line_active`, pulse `line_end` with `line_len` = counter, clear the counter and `line_active`.
- A TERM on an inactive line produces nothing. So CRLF and blank lines yield a single `line_end` or none.
- A line of only errors gives `line_end` with `line_len=0`.

## Timing

- Reset: state IDLE, acc/neg/ovf/counter/`line_active` = 0. All outputs 0: `num_valid`, `num_data`, `line_end`, `line_len`, `err`.
- All outputs are registered, updated on the clock edge after the `uart_rx_done` cycle (latency 1).
- Strobes are high for exactly one cycle.
- When a TERM closes a token, `num_valid`/`err` and `line_end` assert in the same cycle.
- `num_valid` and `err` are never high together.
- Back-to-back `uart_rx_done` on consecutive cycles must be handled; each byte is processed independently.
- `clr` has priority over `uart_rx_done` in the same cycle; that byte is dropped and no strobe fires the following cycle.
- `clr` does not alter held `num_data`/`line_len`.
- Reset asserted mid-token clears everything asynchronously. No strobe fires for the aborted token after release.

## Test plan

- "12 -7\r\n" -> `num_valid` with 12, then `num_valid` with -7 (`num_data`=0xF9) in the same cycle as `line_end`, `line_len`=2. The LF produces no strobe.
- Default params, "128,-128,127\n" -> `err` for 128, `num_valid` -128 (0x80), `num_valid` 127 with `line_end`, `line_len`=2.
- "99999999 5\n" -> `err` (overflow), then `num_valid` 5 with `line_end`, `line_len`=1.
- "-\n" -> `err` and `line_end` with `line_len`=0. Then "1a2 3\n" -> `err` on the space, then `num_valid` 3 with `line_end`, `line_len`=1.
- "45", then `clr` pulse, then " \n" -> no `num_valid`, no `err`, no `line_end`. Also `clr` coincident with a SEP byte after "45" -> no strobe.
- "7 8", then `rst_n` low mid-stream, release, then "\n" -> after the earlier `num_valid` 7 there is no strobe. All outputs read 0 after reset.
